// File: rtl/montgomery_exp_ctrl_if.sv
// rtl/montgomery_exp_ctrl_if.sv - operand/result bus between the exponentiation sequencer and a Montgomery core
interface montgomery_exp_ctrl_if #(
  parameter int WIDTH = 512
);
  logic             mm_start;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_m;
  logic [WIDTH-1:0] mm_result;
  logic             mm_done;

  modport master (
    output mm_start, mm_a, mm_b, mm_m,
    input  mm_result, mm_done
  );

  modport slave (
    input  mm_start, mm_a, mm_b, mm_m,
    output mm_result, mm_done
  );
endinterface

// File: rtl/montgomery_exp_ctrl.sv
// rtl/montgomery_exp_ctrl.sv - X^E mod M by left-to-right square-and-multiply over an external Montgomery core
module montgomery_exp_ctrl #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512,
  parameter int LEN_W     = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]     in_e_len,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_rsq,
  montgomery_exp_ctrl_if.master mm,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy
);
  typedef enum logic [2:0] {
    S_IDLE, S_TOMONT, S_SQUARE, S_MULT, S_FROMMONT, S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t               state_q;
  logic                 wait_q;
  logic [EXP_WIDTH-1:0] e_q;
  logic [LEN_W-1:0]     t_q;
  logic [LEN_W-1:0]     idx_q;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     xm_q;
  logic [WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     mm_a_q;
  logic [WIDTH-1:0]     mm_b_q;
  logic [WIDTH-1:0]     mm_m_q;
  logic                 mm_start_q;
  logic                 done_q;
  logic                 busy_q;

  logic [LEN_W-1:0]     t_d;
  logic                 ebit_d;
  logic                 last_d;

  assign t_d    = (in_e_len > LEN_W'(EXP_WIDTH)) ? LEN_W'(EXP_WIDTH) : in_e_len;
  assign ebit_d = |(e_q & (EXP_WIDTH'(1) << idx_q));
  assign last_d = (idx_q == '0);

  // Each operation: one ISSUE cycle (wait_q=0) then WAIT until mm_done; next operands
  // are loaded on the mm_done edge so the following ISSUE starts immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wait_q     <= 1'b0;
      e_q        <= '0;
      t_q        <= '0;
      idx_q      <= '0;
      r_q        <= '0;
      xm_q       <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_m_q     <= '0;
      mm_start_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      mm_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            e_q        <= in_e;
            t_q        <= t_d;
            r_q        <= in_r;
            mm_m_q     <= in_m;
            mm_a_q     <= in_x;
            mm_b_q     <= in_rsq;
            mm_start_q <= 1'b1;
            wait_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_TOMONT;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else if (mm.mm_done) begin
            wait_q <= 1'b0;
            case (state_q)
              S_TOMONT: begin
                xm_q       <= mm.mm_result;
                acc_q      <= r_q;
                idx_q      <= t_q - LEN_W'(1);
                mm_a_q     <= r_q;
                mm_start_q <= 1'b1;
                if (t_q != '0) begin
                  mm_b_q  <= r_q;
                  state_q <= S_SQUARE;
                end else begin
                  mm_b_q  <= ONE;
                  state_q <= S_FROMMONT;
                end
              end
              S_SQUARE: begin
                acc_q      <= mm.mm_result;
                mm_a_q     <= mm.mm_result;
                mm_start_q <= 1'b1;
                if (ebit_d) begin
                  mm_b_q  <= xm_q;
                  state_q <= S_MULT;
                end else if (last_d) begin
                  mm_b_q  <= ONE;
                  state_q <= S_FROMMONT;
                end else begin
                  mm_b_q  <= mm.mm_result;
                  idx_q   <= idx_q - LEN_W'(1);
                  state_q <= S_SQUARE;
                end
              end
              S_MULT: begin
                acc_q      <= mm.mm_result;
                mm_a_q     <= mm.mm_result;
                mm_start_q <= 1'b1;
                if (last_d) begin
                  mm_b_q  <= ONE;
                  state_q <= S_FROMMONT;
                end else begin
                  mm_b_q  <= mm.mm_result;
                  idx_q   <= idx_q - LEN_W'(1);
                  state_q <= S_SQUARE;
                end
              end
              default: begin
                result_q <= mm.mm_result;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign mm.mm_start = mm_start_q;
  assign mm.mm_a     = mm_a_q;
  assign mm.mm_b     = mm_b_q;
  assign mm.mm_m     = mm_m_q;
  assign result      = result_q;
  assign done        = done_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// tb/tb_montgomery_exp_ctrl.sv - scoreboard bench for montgomery_exp_ctrl with a behavioural Montgomery core
module tb_montgomery_exp_ctrl;
  localparam int W  = 512;
  localparam int EW = 512;
  localparam int LW = 10;

  typedef logic [W-1:0]   word_t;
  typedef logic [2*W-1:0] wide_t;
  typedef struct {
    word_t res;
    int    ops;
    word_t fa;
    word_t fb;
    word_t m;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  word_t         in_x = '0;
  logic [EW-1:0] in_e = '0;
  logic [LW-1:0] in_e_len = '0;
  word_t         in_m = '0;
  word_t         in_r = '0;
  word_t         in_rsq = '0;
  word_t         result;
  logic          done;
  logic          busy;

  montgomery_exp_ctrl_if #(.WIDTH(W)) mmif();

  montgomery_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_x(in_x), .in_e(in_e),
    .in_e_len(in_e_len), .in_m(in_m), .in_r(in_r), .in_rsq(in_rsq),
    .mm(mmif), .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   exp_dones = 0;
  int   lat_lo = 1;
  int   lat_hi = 1;
  exp_t exp_q[$];

  task automatic chk(input string name, input word_t act, input word_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic word_t mulmod(input word_t a, input word_t b, input word_t m);
    wide_t p;
    p = wide_t'(a) * wide_t'(b);
    return W'(p % wide_t'(m));
  endfunction

  // Right-to-left binary exponentiation in the normal domain.
  function automatic word_t ref_modexp(input word_t x, input logic [EW-1:0] e, input int t, input word_t m);
    word_t acc, base;
    acc  = W'(1);
    base = x;
    for (int i = 0; i < t; i++) begin
      if (e[i]) acc = mulmod(acc, base, m);
      base = mulmod(base, base, m);
    end
    return acc;
  endfunction

  function automatic word_t r_of(input word_t m);
    wide_t one_r;
    one_r = wide_t'(1) << W;
    return W'(one_r % wide_t'(m));
  endfunction

  // a*b*2^-W mod m, by halving modulo m once per bit of a.
  function automatic word_t mont(input word_t a, input word_t b, input word_t m);
    logic [W+1:0] y;
    y = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) y = y + {2'b00, b};
      if (y[0]) y = y + {2'b00, m};
      y = y >> 1;
    end
    if (y >= {2'b00, m}) y = y - {2'b00, m};
    return y[W-1:0];
  endfunction

  function automatic word_t rand_word();
    word_t v;
    for (int k = 0; k < W/32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic run_job(input word_t x, input logic [EW-1:0] e, input int len, input word_t m);
    exp_t  ex;
    word_t r;
    int    tc;
    r      = r_of(m);
    tc     = (len > EW) ? EW : len;
    ex.res = ref_modexp(x, e, tc, m);
    ex.ops = 2 + tc;
    for (int i = 0; i < tc; i++) if (e[i]) ex.ops++;
    ex.fa  = x;
    ex.fb  = mulmod(r, r, m);
    ex.m   = m;
    in_x = x; in_e = e; in_e_len = LW'(len); in_m = m; in_r = r; in_rsq = ex.fb;
    exp_q.push_back(ex);
    exp_dones++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (exp_q.size() != 0 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk("job_timeout_pending", word_t'(exp_q.size()), '0);
    if (exp_q.size() != 0) begin
      exp_dones -= exp_q.size();
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_mm_starts(input int n);
    int cnt = 0;
    for (int c = 0; c < 5000; c++) begin
      if (mmif.mm_start) cnt++;
      if (cnt >= n) break;
      @(negedge clk);
    end
    chk("reach_operation", word_t'(cnt >= n), word_t'(1));
  endtask

  // Behavioural core: latency lat_lo..lat_hi cycles, aborts on reset.
  initial begin : core_model
    word_t res;
    int    lat;
    bit    aborted;
    mmif.mm_done   = 1'b0;
    mmif.mm_result = '0;
    forever begin
      @(negedge clk);
      if (resetn && mmif.mm_start) begin
        res     = mont(mmif.mm_a, mmif.mm_b, mmif.mm_m);
        lat     = $urandom_range(lat_hi, lat_lo);
        aborted = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(posedge clk);
          if (!resetn) aborted = 1'b1;
        end
        if (!aborted && resetn) begin
          #1;
          mmif.mm_done   = 1'b1;
          mmif.mm_result = res;
          @(posedge clk);
          #1;
          mmif.mm_done   = 1'b0;
        end
      end
    end
  end

  int    job_ops;
  bit    waiting, prev_mmd, chk_busy;
  word_t ca, cb, cm, fa, fb, fm, lb;

  initial begin : monitor
    exp_t ex;
    job_ops = 0; waiting = 0; prev_mmd = 0; chk_busy = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        job_ops = 0; waiting = 0; prev_mmd = 0; chk_busy = 0;
      end else begin
        if (chk_busy) begin
          chk("busy_after_done", word_t'(busy), '0);
          chk_busy = 0;
        end
        if (mmif.mm_start) begin
          chk("mm_start_during_wait", word_t'(waiting), '0);
          if (job_ops > 0) chk("issue_after_mm_done", word_t'(prev_mmd), word_t'(1));
          else begin
            fa = mmif.mm_a; fb = mmif.mm_b; fm = mmif.mm_m;
          end
          ca = mmif.mm_a; cb = mmif.mm_b; cm = mmif.mm_m; lb = mmif.mm_b;
          waiting = 1;
          job_ops++;
        end else if (waiting) begin
          chk("mm_a_stable", mmif.mm_a, ca);
          chk("mm_b_stable", mmif.mm_b, cb);
          chk("mm_m_stable", mmif.mm_m, cm);
          if (mmif.mm_done) waiting = 0;
        end
        if (done) begin
          done_cnt++;
          chk("done_after_mm_done", word_t'(prev_mmd), word_t'(1));
          chk("busy_in_done", word_t'(busy), word_t'(1));
          chk("job_pending_at_done", word_t'(exp_q.size() != 0), word_t'(1));
          if (exp_q.size() != 0) begin
            ex = exp_q.pop_front();
            chk("result", result, ex.res);
            chk("op_count", word_t'(job_ops), word_t'(ex.ops));
            chk("first_a", fa, ex.fa);
            chk("first_b", fb, ex.fb);
            chk("mm_m", fm, ex.m);
            chk("last_b_one", lb, word_t'(1));
          end
          job_ops  = 0;
          chk_busy = 1;
        end
        prev_mmd = mmif.mm_done;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    word_t m, x;
    repeat (3) @(negedge clk);
    chk("rst_mm_start", word_t'(mmif.mm_start), '0);
    chk("rst_done", word_t'(done), '0);
    chk("rst_busy", word_t'(busy), '0);
    chk("rst_result", result, '0);
    chk("rst_mm_a", mmif.mm_a, '0);
    chk("rst_mm_b", mmif.mm_b, '0);
    chk("rst_mm_m", mmif.mm_m, '0);
    resetn = 1'b1;
    @(negedge clk);

    lat_lo = 3; lat_hi = 3;
    run_job(3, 5, 3, 13);
    wait_idle();
    run_job(7, 0, 0, 13);
    wait_idle();

    lat_lo = 1; lat_hi = 2;
    m = rand_word(); m[W-1] = 1'b1; m[0] = 1'b1;
    x = rand_word() % m;
    run_job(x, {EW{1'b1}}, 512, m);
    wait_idle();

    lat_lo = 1; lat_hi = 20;
    run_job(5, 'hB, 4, 13);
    wait_idle();

    lat_lo = 3; lat_hi = 3;
    run_job(3, 5, 3, 13);
    wait_mm_starts(2);
    @(negedge clk);
    in_x = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_x = 3;
    wait_idle();

    run_job(3, 5, 3, 13);
    wait_mm_starts(3);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abort_mm_start", word_t'(mmif.mm_start), '0);
    chk("abort_done", word_t'(done), '0);
    chk("abort_busy", word_t'(busy), '0);
    chk("abort_result", result, '0);
    chk("abort_mm_a", mmif.mm_a, '0);
    chk("abort_mm_b", mmif.mm_b, '0);
    chk("abort_mm_m", mmif.mm_m, '0);
    exp_dones -= exp_q.size();
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_job(3, 5, 3, 13);
    wait_idle();

    lat_lo = 1; lat_hi = 4;
    for (int j = 0; j < 6; j++) begin
      if (j % 2 == 0) begin
        m = rand_word(); m[W-1] = 1'b1; m[0] = 1'b1;
      end else begin
        m = word_t'($urandom_range(1000, 3) | 1);
      end
      x = rand_word() % m;
      run_job(x, rand_word(), (j == 5) ? 700 : int'($urandom_range(40, 1)), m);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    chk("done_count", word_t'(done_cnt), word_t'(exp_dones));
    chk("scoreboard_empty", word_t'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/montgomery_exp_ctrl.md
Name: montgomery_exp_ctrl

Overview:
- Sequencer that computes result = X^E mod M by driving one external Montgomery multiplier core through its start/done handshake. Uses left-to-right square-and-multiply.
- Sits between the RSA top level and the Montgomery core, which is instantiated beside it.
- Owns all operand selection, exponent-bit scanning and Montgomery domain conversion (in with R^2 mod M, out with multiply-by-1).

Parameters:
- WIDTH, 512, operand/modulus width in bits
- EXP_WIDTH, 512, maximum exponent width in bits
- LEN_W, 10, width of exponent-length field; must be at least clog2(EXP_WIDTH+1)

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; operands sampled on this edge when idle
- in_x  in  WIDTH  base X, normal domain, X < M
- in_e  in  EXP_WIDTH  exponent E
- in_e_len  in  LEN_W  number of significant exponent bits t (0..EXP_WIDTH)
- in_m  in  WIDTH  odd modulus M
- in_r  in  WIDTH  R mod M (Montgomery one), R = 2^WIDTH
- in_rsq  in  WIDTH  R^2 mod M
- mm_start  out  1  one-cycle start pulse to Montgomery core
- mm_a  out  WIDTH  core operand A
- mm_b  out  WIDTH  core operand B
- mm_m  out  WIDTH  core modulus (registered copy of in_m)
- mm_result  in  WIDTH  core result, valid when mm_done=1
- mm_done  in  1  core completion pulse
- result  out  WIDTH  X^E mod M, held until next accepted start
- done  out  1  one-cycle completion pulse
- busy  out  1  high from accepted start until done cycle inclusive

Behaviour:
- Reset (async, resetn=0): state=IDLE. mm_start, done and busy are 0. result, mm_a, mm_b, mm_m and all internal registers are 0. Reset asserted mid-operation aborts immediately. No done pulse is produced for the aborted job. The core must be reset by the same resetn.
- IDLE: when start=1, latch x, e, t, m, r, rsq into internal registers, set busy=1 and go to TOMONT. start while busy is ignored; the latched operands are unaffected.
- Each operation state has two phases: ISSUE (mm_start=1 for exactly one cycle) and WAIT (mm_start=0 until mm_done=1). mm_a, mm_b and mm_m are registered and stable from the ISSUE cycle through the mm_done cycle. mm_done outside WAIT is ignored.
- TOMONT: a=x, b=rsq. On mm_done, Xm<=mm_result and acc<=r. Bit index i<=t-1. Go to SQUARE if t>0, else FROMMONT.
- SQUARE: a=acc, b=acc. On mm_done, acc<=mm_result. If e[i]=1 go to MULT. Else, if i=0 go to FROMMONT, otherwise i<=i-1 and go to SQUARE.
- MULT: a=acc, b=Xm. On mm_done, acc<=mm_result. If i=0 go to FROMMONT, otherwise i<=i-1 and go to SQUARE.
- FROMMONT: a=acc, b=1 (zero-extended). On mm_done, result<=mm_result and go to DONE.
- DONE: done=1 for one cycle, busy=1 in this cycle; next state IDLE. The cycle after DONE returns to IDLE, where a new start is accepted.
- Timing: the next ISSUE cycle (or the DONE cycle) is exactly the cycle after the mm_done cycle, so controller overhead is 1 cycle per operation. The core latency is arbitrary (≥1 cycle) and may vary between operations.
- Operation count per job is 2 + t + popcount(e[t-1:0]).
- Exponent bits above t-1 are ignored. in_e_len > EXP_WIDTH is clamped to EXP_WIDTH.
- Index i is LEN_W wide; no wrap-around, because termination is tested at i=0 before decrementing.
- Operand validity (M odd, X < M, consistent r/rsq) is the caller's responsibility. The controller performs no checks.

Test Plan:
- Core with fixed 3-cycle latency. WIDTH=512, M=13, X=3, E=5, t=3, r=2^512 mod 13, rsq=r^2 mod 13 -> exactly 7 mm_start pulses in order TOMONT,SQ,MUL,SQ,SQ,MUL,FROMMONT. Then done pulse, result=9, busy low the following cycle.
- E=0, t=0, X=7, M=13 -> 2 mm_start pulses (TOMONT, FROMMONT); result=1.
- E=2^512-1, t=512, X=2, M=2^511+... (odd prime from golden model) -> 1026 mm_start pulses; result matches software modexp.
- Variable core latency (random 1..20 cycles per op) with E=0xB, t=4, M=13, X=5 -> result=5^11 mod 13=8. mm_a, mm_b and mm_m stable throughout each WAIT. Each mm_start occurs exactly 1 cycle after the preceding mm_done.
- start pulsed again during SQUARE with different in_x -> ignored; result still equals the first job's value; exactly one done pulse.
- resetn dropped for 1 cycle during MULT -> outputs 0 immediately, no done pulse. A fresh start afterwards produces the correct result (3^5 mod 13=9).
